// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: request direction codes,
// FSM state encoding and the address range helper.
package data_mem_responder_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int DMEM_LANES = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // Out of range when any byte-address bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_width);
        logic [31:0] upper;
        upper = addr >> (addr_width + 2);
        return (upper != 32'd0);
    endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Synchronous single-port word RAM with per-byte-lane write enables and a
// registered, read-enabled output. Lane i covers bits 8*i+7 : 8*i.
module byte_en_ram
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_re,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // Lane-masked write; array contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DMEM_LANES; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Registered read port, only the output register is cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= 32'd0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end else begin
            o_rdata <= o_rdata;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one request, waits LATENCY busy cycles,
// commits it to the byte-enabled RAM and pulses ack in a DONE cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_enable,
    input  logic                  i_mem_rw,
    input  logic [31:0]           i_mem_addr,
    input  logic [3:0]            i_mem_sel,
    input  logic [DATA_WIDTH-1:0] i_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_read,
    output logic                  o_stall,
    output logic                  o_ack,
    output logic                  o_addr_error
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_oor;
    logic [3:0]            r_sel;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_ram_re;
    logic [3:0]            w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_accept = (r_state == DMEM_IDLE) && i_mem_enable;
    assign w_commit = (r_state == DMEM_BUSY) && (r_cnt == {CNT_W{1'b0}});

    // RAM port steering: the read is issued as the request is latched, so the
    // word is already registered by commit; the write happens at commit.
    always_comb begin
        w_ram_re   = 1'b0;
        w_ram_we   = 4'b0000;
        w_ram_addr = r_addr;
        if (w_accept) begin
            w_ram_re   = (i_mem_rw == MEM_READ);
            w_ram_addr = i_mem_addr[ADDR_WIDTH+1:2];
        end else if (w_commit && (r_rw == MEM_WRITE) && !r_oor) begin
            w_ram_we   = r_sel;
        end else begin
            w_ram_we   = 4'b0000;
        end
    end

    byte_en_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Request handshake FSM with latency counter, request latch and outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= DMEM_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_rw         <= MEM_READ;
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_oor        <= 1'b0;
            r_sel        <= 4'b0000;
            r_wdata      <= {DATA_WIDTH{1'b0}};
            o_mem_read   <= {DATA_WIDTH{1'b0}};
            o_ack        <= 1'b0;
            o_addr_error <= 1'b0;
        end else begin
            o_ack        <= 1'b0;
            o_addr_error <= 1'b0;
            case (r_state)
                DMEM_IDLE: begin
                    if (i_mem_enable) begin
                        r_rw    <= i_mem_rw;
                        r_addr  <= i_mem_addr[ADDR_WIDTH+1:2];
                        r_oor   <= addr_out_of_range(i_mem_addr, ADDR_WIDTH);
                        r_sel   <= i_mem_sel;
                        r_wdata <= i_mem_write;
                        r_cnt   <= CNT_LOAD;
                        r_state <= DMEM_BUSY;
                    end else begin
                        r_state <= DMEM_IDLE;
                    end
                end
                DMEM_BUSY: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        if (r_rw == MEM_READ) begin
                            o_mem_read <= r_oor ? {DATA_WIDTH{1'b0}} : w_ram_rdata;
                        end else begin
                            o_mem_read <= o_mem_read;
                        end
                        o_ack        <= 1'b1;
                        o_addr_error <= r_oor;
                        r_state      <= DMEM_DONE;
                    end
                end
                DMEM_DONE: begin
                    r_state <= DMEM_IDLE;
                end
                default: begin
                    r_state <= DMEM_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accepting IDLE cycle and every BUSY cycle.
    always_comb begin
        o_stall = 1'b0;
        if (i_rst) begin
            o_stall = 1'b0;
        end else if (w_accept || (r_state == DMEM_BUSY)) begin
            o_stall = 1'b1;
        end else begin
            o_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized traffic compared against a byte-addressed memory model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic          mem_enable;
    logic          mem_rw;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_sel;
    logic [DW-1:0] mem_write;
    logic [DW-1:0] mem_read;
    logic          stall;
    logic          ack;
    logic          addr_error;

    int checks;
    int failures;

    // Byte-addressed model, big-endian: byte offset 0 is bits 31:24.
    logic [7:0]  bmem [int];
    logic [31:0] last_rd;

    data_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_enable (mem_enable),
        .i_mem_rw     (mem_rw),
        .i_mem_addr   (mem_addr),
        .i_mem_sel    (mem_sel),
        .i_mem_write  (mem_write),
        .o_mem_read   (mem_read),
        .o_stall      (stall),
        .o_ack        (ack),
        .o_addr_error (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return (a >= (32'd1 << (AW + 2)));
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        logic [31:0] w;
        base = int'({a[31:2], 2'b00});
        w = 32'd0;
        for (int k = 0; k < 4; k++) begin
            w = {w[23:0], bmem.exists(base + k) ? bmem[base + k] : 8'hxx};
        end
        return w;
    endfunction

    task automatic model_commit(input logic rw, input logic [31:0] a,
                                input logic [3:0] sel, input logic [31:0] wd);
        int base;
        base = int'({a[31:2], 2'b00});
        if (rw == MEM_READ) begin
            last_rd = is_oor(a) ? 32'd0 : model_word(a);
        end else if (!is_oor(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[3 - k]) bmem[base + k] = wd[31 - 8*k -: 8];
            end
        end
    endtask

    // Issue one request and check stall/ack/error/read timing cycle by cycle.
    task automatic req(input logic rw, input logic [31:0] a, input logic [3:0] sel,
                       input logic [31:0] wd, input bit keep);
        mem_enable = 1'b1;
        mem_rw     = rw;
        mem_addr   = a;
        mem_sel    = sel;
        mem_write  = wd;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c <= LAT) begin
                chk($sformatf("stall_c%0d", c), {31'd0, stall}, 32'd1);
                chk($sformatf("noack_c%0d", c), {31'd0, ack}, 32'd0);
            end else begin
                chk("done_ack", {31'd0, ack}, 32'd1);
                chk("done_stall", {31'd0, stall}, 32'd0);
                chk("done_err", {31'd0, addr_error}, {31'd0, is_oor(a)});
                chk("done_rdata", mem_read, last_rd);
            end
            if (c == LAT) model_commit(rw, a, sel, wd);
            @(posedge clk);
            #1;
        end
        if (!keep) mem_enable = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_rd"}, mem_read, last_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic        rrw;
        checks     = 0;
        failures   = 0;
        last_rd    = 32'd0;
        rst        = 1'b1;
        mem_enable = 1'b1;
        mem_rw     = MEM_WRITE;
        mem_addr   = 32'h0000_0020;
        mem_sel    = 4'b1111;
        mem_write  = 32'd0;

        // Reset with a pending request: stall suppressed, outputs cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, addr_error}, 32'd0);
        chk("rst_rd", mem_read, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req(MEM_WRITE, 32'h0000_0020, 4'b1111, 32'h0000_0000, 1'b0);
        idle_check("post_rst");

        // Word store/load, then byte and halfword lane updates.
        req(MEM_WRITE, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        req(MEM_READ,  32'h0000_0010, 4'b0000, 32'h0, 1'b0);
        chk("sw_lw", mem_read, 32'hDEAD_BEEF);
        req(MEM_WRITE, 32'h0000_0010, 4'b0100, 32'h1111_1111, 1'b0);
        req(MEM_READ,  32'h0000_0013, 4'b1111, 32'h0, 1'b0);
        chk("sb", mem_read, 32'hDE11_BEEF);
        req(MEM_WRITE, 32'h0000_0010, 4'b0011, 32'h2222_2222, 1'b0);
        req(MEM_READ,  32'h0000_0010, 4'b0001, 32'h0, 1'b0);
        chk("sh", mem_read, 32'hDE11_2222);
        req(MEM_WRITE, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        req(MEM_READ,  32'h0000_0010, 4'b0000, 32'h0, 1'b0);
        chk("sel0_noop", mem_read, 32'hDE11_2222);

        // Out of range: read returns 0, write must not alias onto word 0.
        req(MEM_WRITE, 32'h0000_0000, 4'b1111, 32'h1234_5678, 1'b0);
        req(MEM_READ,  32'h0000_1000, 4'b1111, 32'h0, 1'b0);
        chk("oor_rd", mem_read, 32'd0);
        req(MEM_WRITE, 32'h0000_1000, 4'b1111, 32'hAAAA_AAAA, 1'b0);
        req(MEM_WRITE, 32'h8000_0000, 4'b1111, 32'hBBBB_BBBB, 1'b0);
        req(MEM_READ,  32'h0000_0000, 4'b1111, 32'h0, 1'b0);
        chk("oor_wr_word0", mem_read, 32'h1234_5678);

        // Back-to-back: enable held through DONE straight into a new store.
        req(MEM_READ,  32'h0000_0010, 4'b1111, 32'h0, 1'b1);
        req(MEM_WRITE, 32'h0000_0014, 4'b1111, 32'h5555_AAAA, 1'b0);
        idle_check("b2b");
        req(MEM_READ,  32'h0000_0014, 4'b1111, 32'h0, 1'b0);
        chk("b2b_rd", mem_read, 32'h5555_AAAA);

        // Reset in the first BUSY cycle drops the uncommitted store.
        mem_enable = 1'b1;
        mem_rw     = MEM_WRITE;
        mem_addr   = 32'h0000_0020;
        mem_sel    = 4'b1111;
        mem_write  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_rd", mem_read, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem_enable = 1'b0;
        last_rd    = 32'd0;
        idle_check("midrst_idle");
        req(MEM_READ, 32'h0000_0020, 4'b1111, 32'h0, 1'b0);
        chk("midrst_drop", mem_read, 32'd0);

        // Randomized traffic over 16 pre-initialised words plus stray addresses.
        for (int i = 0; i < 16; i++) begin
            req(MEM_WRITE, 32'(i * 4), 4'b1111, $urandom, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            rrw = 1'($urandom_range(1, 0));
            if ($urandom_range(9, 0) == 0) ra = 32'h0000_1000 | 32'($urandom_range(15, 0) * 4);
            else ra = 32'($urandom_range(15, 0) * 4) | 32'($urandom_range(3, 0));
            req(rrw, ra, 4'($urandom_range(15, 0)), $urandom, bit'($urandom_range(1, 0)));
        end
        mem_enable = 1'b0;
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the EX/MEM stage's data-memory request port. It accepts one word-aligned request per handshake (address, read/write, big-endian byte strobes, write data). It performs the access in a byte-enabled RAM after a fixed latency, returns the full read word, and holds the pipeline with `stall` until the access completes. Byte extraction and sign extension for loads, and data replication for stores, stay in the pipeline stage; this block only honours strobes and returns whole words.

## Interface
- `DATA_WIDTH`, 32: data word width; only 32 supported.
- `ADDR_WIDTH`, 10: word-address bits; RAM depth is 2^ADDR_WIDTH words.
- `LATENCY`, 2: BUSY cycles before the access commits; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_enable`  in  1  request valid; held stable by the pipeline while `stall`=1.
- `mem_rw`  in  1  `MEM_READ` / `MEM_WRITE`.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_sel`  in  4  byte strobes; `mem_sel[3]` → bits 31:24 (byte offset 0, big-endian).
- `mem_write`  in  32  write data, already lane-aligned.
- `mem_read`  out  32  registered read word.
- `stall`  out  1  hold the pipeline.
- `ack`  out  1  one-cycle completion pulse.
- `addr_error`  out  1  one-cycle pulse with `ack` for an out-of-range address.

## Operation
- States: IDLE, BUSY, DONE; counter width is clog2(LATENCY).
- IDLE:
  - If `mem_enable`=1, latch addr/rw/sel/wdata, load counter with LATENCY-1, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If counter≠0, decrement it.
  - If counter=0, commit the access and go to DONE.
  - Write commit: for each set `mem_sel[i]`, update lane i of word `addr[ADDR_WIDTH+1:2]`. `mem_sel`=0 is a legal no-op write.
  - Read commit: load `mem_read` with the whole word; `mem_sel` is ignored.
- DONE: `ack`=1 and `stall`=0, then go to IDLE unconditionally. The pipeline advances on this edge, so the still-asserted `mem_enable` is never re-sampled as a new request.
- `stall` is combinational: (IDLE && `mem_enable`) || BUSY. It is forced to 0 while `rst`=1.
- Out of range: a request is out of range when `addr[31:ADDR_WIDTH+2]`≠0.
  - A write is suppressed.
  - A read loads 0.
  - `addr_error` pulses in DONE.
- `mem_read` holds its value until the next read commits; writes and errors on writes leave it unchanged.
- No abort: a request that has entered BUSY always completes. Flushes are applied by the pipeline after the handshake.

## Timing
- Reset values: state IDLE, counter 0, `mem_read`=0, `ack`=0, `addr_error`=0, `stall`=0. RAM contents are not reset.
- Request first seen in cycle 0:
  - `stall`=1 in cycles 0..LATENCY.
  - Commit happens on the edge ending cycle LATENCY.
  - DONE is cycle LATENCY+1, where `ack`=1 and `mem_read` is valid.
- Total occupancy is LATENCY+2 cycles per request. A back-to-back request is sampled in the cycle after DONE.
- Read-after-write to the same word returns the written data, because the commits are serialized.
- Reset mid-operation: return to IDLE immediately. An uncommitted write is dropped; a committed write persists.
- `mem_enable` deasserting during BUSY is a protocol violation; the latched request still completes.

## Structure
- The shared defines package holds `MEM_READ`/`MEM_WRITE` (already defined there) and the state encoding constants `DMEM_IDLE`, `DMEM_BUSY`, `DMEM_DONE`.
- One sub-module, `byte_en_ram`: a synchronous single-port RAM with a 4-bit lane write enable and a registered read, parameterised by ADDR_WIDTH.
- The FSM, counter, request latch and error check live in the top module.

## Test plan
- Reset, LATENCY=2: `rst` pulse with `mem_enable`=1 → `stall`=0 during reset, all outputs 0 after reset, `stall`=1 the cycle after release.
- SW then LW at 0x0000_0010: write 0xDEADBEEF with sel=1111 → `stall` high 3 cycles, `ack` in cycle 3. Read back → `mem_read`=0xDEADBEEF with `ack`.
- SB lanes at 0x10: write 0x11111111 with sel=0100, then read → `mem_read`=0xDE11BEEF. SH with sel=0011 and data 0x22222222, then read → 0xDE112222.
- Out of range (ADDR_WIDTH=10): LW at 0x0000_1000 → `mem_read`=0 and `addr_error`=1 together with `ack`. SW at 0x0000_1000 → no RAM word changes.
- Back-to-back: a LW held through DONE, then immediately a new SW → exactly one `ack` per request, and the second request latched the cycle after DONE.
- Reset mid-BUSY during SW of 0xCAFEF00D to 0x20 (old value 0): after reset, LW at 0x20 returns 0.
